// File: rtl/apb_pkg.sv
// Shared definitions for the APB master controller and its helpers.
package apb_pkg;

    localparam int APB_ADDR_W = 2;
    localparam int APB_DATA_W = 8;
    localparam int WAIT_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles spent waiting for PREADY and flags the abort point.
module apb_wait_timer
    import apb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  count,
    input  logic [WAIT_CNT_W-1:0] limit,
    output logic                  expired
);

    logic [WAIT_CNT_W-1:0] wait_cnt;

    // Wait counter: cleared before each ACCESS phase, saturates rather than wraps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (clear) begin
            wait_cnt <= '0;
        end else if (count && (wait_cnt != {WAIT_CNT_W{1'b1}})) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // A zero limit disables the abort entirely.
    assign expired = (limit != '0) && (wait_cnt == (limit - 1'b1));

endmodule

// File: rtl/apb_master_ctrl.sv
// APB initiator: turns a valid/ready command into one SETUP/ACCESS transfer
// and reports completion, slave error or wait-state timeout as a response pulse.
module apb_master_ctrl
    import apb_pkg::*;
#(
    parameter int ADDR_W      = APB_ADDR_W,
    parameter int DATA_W      = APB_DATA_W,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR,
    output logic              busy
);

    apb_state_t state;
    logic       timer_expired;
    logic       timer_clear;
    logic       timer_count;

    // The counter restarts while in SETUP so it reads zero on the first ACCESS cycle.
    assign timer_clear = (state == SETUP);
    assign timer_count = (state == ACCESS) && !PREADY;

    apb_wait_timer u_wait_timer (
        .clk     (PCLK),
        .rst_n   (PRESETn),
        .clear   (timer_clear),
        .count   (timer_count),
        .limit   (WAIT_CNT_W'(TIMEOUT_CYC)),
        .expired (timer_expired)
    );

    // Transfer sequencer with every output registered alongside the state.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_ready && cmd_valid) begin
                        state     <= SETUP;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        PSEL      <= 1'b1;
                        PENABLE   <= 1'b0;
                        PWRITE    <= cmd_write;
                        PADDR     <= cmd_addr;
                        PWDATA    <= cmd_write ? cmd_wdata : '0;
                    end else begin
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                SETUP: begin
                    state   <= ACCESS;
                    PENABLE <= 1'b1;
                end
                ACCESS: begin
                    if (PREADY || timer_expired) begin
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        PWRITE    <= 1'b0;
                        PADDR     <= '0;
                        PWDATA    <= '0;
                        rsp_valid <= 1'b1;
                        if (PREADY) begin
                            rsp_rdata <= PWRITE ? '0 : PRDATA;
                            rsp_err   <= PSLVERR;
                        end else begin
                            rsp_rdata <= '0;
                            rsp_err   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b0;
                    busy      <= 1'b0;
                    PSEL      <= 1'b0;
                    PENABLE   <= 1'b0;
                    PWRITE    <= 1'b0;
                    PADDR     <= '0;
                    PWDATA    <= '0;
                end
            endcase
        end
    end

endmodule
